// File: rtl/stepper_pkg.sv
// Shared definitions for the multi-channel stepper controller: register map,
// CTRL/STATUS bit positions, channel FSM encoding and the STATUS packer.
package stepper_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STEPS  = 2'd1;
  localparam logic [1:0] REG_PERIOD = 2'd2;
  localparam logic [1:0] REG_HIGH   = 2'd3;

  localparam int CTRL_DIR    = 0;
  localparam int CTRL_START  = 1;
  localparam int CTRL_ABORT  = 2;
  localparam int CTRL_DONE   = 3;
  localparam int CTRL_IRQ_EN = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LOW   = 2'd3
  } step_state_t;

  function automatic logic [31:0] pack_status(input logic [15:0] rem, input logic irq_en,
                                              input logic done, input logic busy,
                                              input logic dir);
    return {rem, 11'd0, irq_en, done, 1'b0, busy, dir};
  endfunction

endpackage

// File: rtl/stepper_channel.sv
// One stepper channel: config registers, latched working copies and the
// IDLE/SETUP/HIGH/LOW pulse FSM. Bit 4 of CTRL exists only with STEPPER_IRQ_EN.
module stepper_channel
  import stepper_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int PER_W     = 16,
  parameter int DIR_SETUP = 50
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ctrl_wr,
  input  logic        steps_wr,
  input  logic        period_wr,
  input  logic        high_wr,
  input  logic [31:0] wdata,
  output logic        step,
  output logic        dir,
`ifdef STEPPER_IRQ_EN
  output logic        irq_pend,
`endif
  output logic [31:0] rd_status,
  output logic [31:0] rd_steps,
  output logic [31:0] rd_period,
  output logic [31:0] rd_high
);

  // The phase counter must also hold the direction setup time.
  localparam int SW = $clog2(DIR_SETUP + 1);
  localparam int TW = (PER_W > SW) ? PER_W : SW;

  step_state_t      state;
  logic             done;
  logic             irq_en;
  logic [CNT_W-1:0] steps_cfg;
  logic [CNT_W-1:0] remaining;
  logic [PER_W-1:0] period_cfg;
  logic [PER_W-1:0] high_cfg;
  logic [PER_W-1:0] high_w;
  logic [PER_W-1:0] low_w;
  logic [PER_W-1:0] per_e;
  logic [PER_W-1:0] high_e;
  logic [TW-1:0]    cnt;
  logic             abort_req;
  logic             start_req;
  logic             unused_bits;

  function automatic logic [PER_W-1:0] clamp_period(input logic [PER_W-1:0] p);
    return (p < PER_W'(2)) ? PER_W'(2) : p;
  endfunction

  function automatic logic [PER_W-1:0] clamp_high(input logic [PER_W-1:0] h,
                                                  input logic [PER_W-1:0] p);
    if (h == PER_W'(0)) return PER_W'(1);
    else if (h >= p) return p - PER_W'(1);
    else return h;
  endfunction

  assign per_e       = clamp_period(period_cfg);
  assign high_e      = clamp_high(high_cfg, per_e);
  assign abort_req   = ctrl_wr & wdata[CTRL_ABORT];
  assign start_req   = ctrl_wr & wdata[CTRL_START] & ~wdata[CTRL_ABORT];
  assign unused_bits = ^wdata;

`ifdef STEPPER_IRQ_EN
  assign irq_pend = done & irq_en;
`else
  assign irq_en = 1'b0;
`endif

  assign rd_status = pack_status(16'(remaining), irq_en, done, state != ST_IDLE, dir);
  assign rd_steps  = 32'(steps_cfg);
  assign rd_period = 32'(period_cfg);
  assign rd_high   = 32'(high_cfg);

  // Config registers and pulse FSM; step and dir are registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      step       <= 1'b0;
      dir        <= 1'b0;
      done       <= 1'b0;
      steps_cfg  <= '0;
      period_cfg <= '0;
      high_cfg   <= '0;
      remaining  <= '0;
      high_w     <= '0;
      low_w      <= '0;
      cnt        <= '0;
`ifdef STEPPER_IRQ_EN
      irq_en     <= 1'b0;
`endif
    end else begin
      if (steps_wr)  steps_cfg  <= wdata[CNT_W-1:0];
      if (period_wr) period_cfg <= wdata[PER_W-1:0];
      if (high_wr)   high_cfg   <= wdata[PER_W-1:0];
`ifdef STEPPER_IRQ_EN
      if (ctrl_wr)   irq_en     <= wdata[CTRL_IRQ_EN];
`endif
      if (ctrl_wr && wdata[CTRL_DONE]) done <= 1'b0;

      if (abort_req && state != ST_IDLE) begin
        step  <= 1'b0;
        state <= ST_IDLE;
        done  <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            step <= 1'b0;
            if (ctrl_wr) dir <= wdata[CTRL_DIR];
            if (start_req) begin
              remaining <= steps_cfg;
              high_w    <= high_e;
              low_w     <= per_e - high_e;
              if (steps_cfg == CNT_W'(0)) begin
                done <= 1'b1;
              end else if (DIR_SETUP == 0) begin
                done  <= 1'b0;
                state <= ST_HIGH;
                step  <= 1'b1;
                cnt   <= TW'(high_e - PER_W'(1));
              end else begin
                done  <= 1'b0;
                state <= ST_SETUP;
                cnt   <= TW'(DIR_SETUP - 1);
              end
            end
          end
          ST_SETUP: begin
            if (cnt == TW'(0)) begin
              state <= ST_HIGH;
              step  <= 1'b1;
              cnt   <= TW'(high_w - PER_W'(1));
            end else begin
              cnt <= cnt - TW'(1);
            end
          end
          ST_HIGH: begin
            if (cnt == TW'(0)) begin
              state <= ST_LOW;
              step  <= 1'b0;
              cnt   <= TW'(low_w - PER_W'(1));
            end else begin
              cnt <= cnt - TW'(1);
            end
          end
          ST_LOW: begin
            if (cnt == TW'(0)) begin
              remaining <= remaining - CNT_W'(1);
              if (remaining == CNT_W'(1)) begin
                state <= ST_IDLE;
                done  <= 1'b1;
              end else begin
                state <= ST_HIGH;
                step  <= 1'b1;
                cnt   <= TW'(high_w - PER_W'(1));
              end
            end else begin
              cnt <= cnt - TW'(1);
            end
          end
          default: begin
            state <= ST_IDLE;
            step  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/stepper_multi_ctrl.sv
// APB3 front end for NUM_CH stepper channels; PADDR[7:4] picks the channel.
// Optional STEPPER_IRQ_EN adds a registered irq output and per-channel enable.
module stepper_multi_ctrl
  import stepper_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int CNT_W     = 16,
  parameter int PER_W     = 16,
  parameter int DIR_SETUP = 50
) (
  input  logic              PCLK,
  input  logic              PRESERN,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [31:0]       PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [NUM_CH-1:0] step,
  output logic [NUM_CH-1:0] dir
`ifdef STEPPER_IRQ_EN
  ,
  output logic              irq
`endif
);

  logic [3:0]             ch;
  logic [1:0]             rsel;
  logic                   wr;
  logic                   unused_addr;
  logic [NUM_CH-1:0][31:0] rd_masked;
`ifdef STEPPER_IRQ_EN
  logic [NUM_CH-1:0]      irq_pend;
`endif

  assign ch          = PADDR[7:4];
  assign rsel        = PADDR[3:2];
  assign wr          = PSEL & PENABLE & PWRITE;
  assign PREADY      = 1'b1;
  assign PSLVERR     = 1'b0;
  assign unused_addr = ^{PADDR[31:8], PADDR[1:0]};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic        hit;
    logic [31:0] rd_status;
    logic [31:0] rd_steps;
    logic [31:0] rd_period;
    logic [31:0] rd_high;
    logic [31:0] rd_word;

    assign hit = wr && (ch == 4'(i));

    stepper_channel #(
      .CNT_W     (CNT_W),
      .PER_W     (PER_W),
      .DIR_SETUP (DIR_SETUP)
    ) u_channel (
      .clk       (PCLK),
      .rst_n     (PRESERN),
      .ctrl_wr   (hit && rsel == REG_CTRL),
      .steps_wr  (hit && rsel == REG_STEPS),
      .period_wr (hit && rsel == REG_PERIOD),
      .high_wr   (hit && rsel == REG_HIGH),
      .wdata     (PWDATA),
      .step      (step[i]),
      .dir       (dir[i]),
`ifdef STEPPER_IRQ_EN
      .irq_pend  (irq_pend[i]),
`endif
      .rd_status (rd_status),
      .rd_steps  (rd_steps),
      .rd_period (rd_period),
      .rd_high   (rd_high)
    );

    // Register select within this channel.
    always_comb begin
      case (rsel)
        REG_CTRL:   rd_word = rd_status;
        REG_STEPS:  rd_word = rd_steps;
        REG_PERIOD: rd_word = rd_period;
        REG_HIGH:   rd_word = rd_high;
        default:    rd_word = 32'd0;
      endcase
    end

    assign rd_masked[i] = (ch == 4'(i)) ? rd_word : 32'd0;
  end

  // Out-of-range channels contribute nothing, so they read as zero.
  always_comb begin
    PRDATA = 32'd0;
    for (int i = 0; i < NUM_CH; i++) begin
      PRDATA = PRDATA | rd_masked[i];
    end
  end

`ifdef STEPPER_IRQ_EN
  // Registered interrupt: any channel with done and its enable set.
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      irq <= 1'b0;
    end else begin
      irq <= |irq_pend;
    end
  end
`endif

endmodule

// File: doc/stepper_multi_ctrl.md
STEPPER_MULTI_CTRL -- requirements
Module: stepper_multi_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of independent stepper channels (1..8).
REQ-002 SHALL have parameter CNT_W, default 16: width of step-count registers and counters.
REQ-003 SHALL have parameter PER_W, default 16: width of period and high-time registers and counters.
REQ-004 SHALL have parameter DIR_SETUP, default 50: PCLK cycles from dir update to first step edge.
REQ-005 SHALL have port PCLK  in  1  the only clock; one clock, all logic on its rising edge.
REQ-006 SHALL have port PRESERN  in  1  reset, asynchronous and active-low.
REQ-007 SHALL have ports PSEL, PENABLE, PWRITE  in  1 each  APB3 select, access phase, write/read.
REQ-008 SHALL have ports PADDR in 32 and PWDATA in 32: APB3 address and write data.
REQ-009 SHALL have ports PRDATA out 32, PREADY out 1 (tied 1), PSLVERR out 1 (tied 0).
REQ-010 SHALL have ports step out NUM_CH and dir out NUM_CH: per-channel driver pins.

Function
REQ-011 SHALL decode channel = PADDR[7:4] and register = PADDR[3:2]: 0 CTRL/STATUS, 1 STEPS, 2 PERIOD, 3 HIGH.
REQ-012 SHALL commit a write only on PSEL & PENABLE & PWRITE; channels >= NUM_CH are ignored on write.
REQ-013 SHALL drive PRDATA combinationally from the addressed register; unmapped or out-of-range addresses read 0.
REQ-014 SHALL implement CTRL write bits: [0] dir, [1] start (self-clearing), [2] abort (self-clearing), [3] write-1-clear done.
REQ-015 SHALL implement STATUS read bits: [0] dir, [1] busy, [3] done (sticky), [31:16] steps remaining (zero-extended or truncated to CNT_W).
REQ-016 SHALL run per-channel FSM IDLE -> SETUP -> HIGH -> LOW -> (HIGH or IDLE).
REQ-017 SHALL, on start in IDLE, latch STEPS/PERIOD/HIGH into working copies, update dir, clear done, and enter SETUP.
REQ-018 SHALL hold SETUP for DIR_SETUP cycles with step low, then enter HIGH.
REQ-019 SHALL assert step for exactly HIGH cycles and deassert it for PERIOD-HIGH cycles per step; step is registered.
REQ-020 SHALL decrement remaining at the end of each LOW phase; at 0 go IDLE and set done the same cycle.
REQ-021 SHALL, on start with STEPS = 0, emit no pulses, skip SETUP, and set done the next cycle.
REQ-022 SHALL treat PERIOD < 2 as 2, HIGH = 0 as 1, and HIGH >= PERIOD as PERIOD-1.
REQ-023 SHALL ignore start while busy; STEPS/PERIOD/HIGH writes while busy affect only the next start.
REQ-024 SHALL, on abort in any non-IDLE state, drive step low and enter IDLE next cycle with done set.
REQ-025 SHALL give abort priority over start when both bits are written in the same cycle.
REQ-026 SHALL keep dir stable while busy; dir writes while busy are ignored.

Reset
REQ-027 SHALL, on PRESERN low, asynchronously force all FSMs to IDLE, step = 0, dir = 0, done = 0, and STEPS/PERIOD/HIGH to 0.
REQ-028 SHALL, on reset mid-pulse, drop step low immediately without completing the pulse.

Configuration
REQ-029 SHALL support macro STEPPER_IRQ_EN; when defined, add output irq (1 bit), CTRL/STATUS bit [4] per-channel irq enable, and irq = OR over channels of (done & irq_en), registered.
REQ-030 SHALL, without STEPPER_IRQ_EN, omit the irq port, read bit [4] as 0, and ignore writes to it.

Structure
REQ-031 SHALL place register offsets, CTRL/STATUS bit positions, and the FSM state encoding in shared package stepper_pkg.
REQ-032 SHALL implement one channel in sub-module stepper_channel, instantiated NUM_CH times by generate; APB decode stays in the top.

Verification
REQ-033 SHALL cover: STEPS=3, PERIOD=200, HIGH=150, start -> 50 cycles low, then 3 pulses of 150 high / 50 low; done=1, busy=0.
REQ-034 SHALL cover: STEPS=0, start -> no step edge; done=1 one cycle after the write.
REQ-035 SHALL cover: PERIOD=10, HIGH=12 -> 9-high/1-low pulses; PERIOD=1 -> behaves as PERIOD=2, HIGH=1.
REQ-036 SHALL cover: abort during the 2nd of 5 pulses -> step low next cycle, remaining=4, done=1; start+abort in the same write -> no motion.
REQ-037 SHALL cover: both channels started 7 cycles apart with different dir -> independent, correct pulse trains; writes to channel 2 (NUM_CH=2) are ignored and read 0.
REQ-038 SHALL cover: PRESERN low mid-HIGH -> step=0 asynchronously; with STEPPER_IRQ_EN, irq rises on done with irq_en=1 and falls on done write-1-clear.
